// File: rtl/div_request_sequencer.sv
// div_request_sequencer: accepts one divide request at a time, screens out
// divide-by-zero and quotient overflow locally, otherwise drives a start pulse
// to an external multi-cycle divider and waits (bounded by TIMEOUT) for done.
// The result is held on the output until the consumer takes it.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              request handshake (ready only in IDLE)
//   in_dividend[11:0], in_divisor[5:0]   request operands
//   div_start, div_dividend, div_divisor  divider command (operands held)
//   div_done, div_quotient, div_rem      divider completion and result
//   out_valid/out_ready            result handshake (valid only in HOLD)
//   out_quotient, out_rem, out_err result; err 00 ok, 01 div0, 10 ovf, 11 timeout
//   busy                           FSM is not in IDLE
//
// Latency: 1 cycle for locally detected errors, ISSUE + WAIT cycles otherwise.
// Backpressure: result held in HOLD until out_ready; no new request accepted
// until the FSM is back in IDLE.
module div_request_sequencer #(
  parameter int unsigned TIMEOUT = 32  // legal range 16..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_dividend,
  input  logic [5:0]  in_divisor,
  output logic        div_start,
  output logic [11:0] div_dividend,
  output logic [5:0]  div_divisor,
  input  logic        div_done,
  input  logic [5:0]  div_quotient,
  input  logic [6:0]  div_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_quotient,
  output logic [6:0]  out_rem,
  output logic [1:0]  out_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // Last counter value allowed in WAIT; counter reads 0 in the first WAIT cycle,
  // so the FSM spends at most TIMEOUT cycles in WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [11:0] dividend_q, dividend_d;
  logic [5:0]  divisor_q, divisor_d;
  logic [5:0]  quot_q, quot_d;
  logic [6:0]  rem_q, rem_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dividend_d = in_dividend;
          divisor_d  = in_divisor;
          if (in_divisor == 6'd0) begin
            state_d = ST_HOLD;
            err_d   = ERR_DIV0;
            quot_d  = 6'h3F;
            rem_d   = 7'd0;
          end else if (in_dividend[11:6] >= in_divisor) begin
            // Quotient would not fit in 6 bits.
            state_d = ST_HOLD;
            err_d   = ERR_OVF;
            quot_d  = 6'h3F;
            rem_d   = 7'd0;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 8'd0;
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // done takes priority over a coincident timeout.
        if (div_done) begin
          state_d = ST_HOLD;
          err_d   = ERR_OK;
          quot_d  = div_quotient;
          rem_d   = div_rem;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_HOLD;
          err_d   = ERR_TMO;
          quot_d  = 6'h3F;
          rem_d   = 7'd0;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dividend_q <= 12'd0;
      divisor_q  <= 6'd0;
      quot_q     <= 6'd0;
      rem_q      <= 7'd0;
      err_q      <= 2'b00;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // All outputs come straight from registers.
  assign in_ready     = (state_q == ST_IDLE);
  assign div_start    = (state_q == ST_ISSUE);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_valid    = (state_q == ST_HOLD);
  assign out_quotient = quot_q;
  assign out_rem      = rem_q;
  assign out_err      = err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_request_sequencer.sv
// Testbench for div_request_sequencer: drives requests, models the external
// divider (done N cycles after start, or never), and scores results from a
// queue of expected values filled at request acceptance.
module tb_div_request_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_dividend = 12'd0;
  logic [5:0]  in_divisor = 6'd0;
  logic        div_start;
  logic [11:0] div_dividend;
  logic [5:0]  div_divisor;
  logic        div_done = 1'b0;
  logic [5:0]  div_quotient = 6'd0;
  logic [6:0]  div_rem = 7'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_quotient;
  logic [6:0]  out_rem;
  logic [1:0]  out_err;
  logic        busy;

  always #5 clk = ~clk;

  div_request_sequencer #(.TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_rem(div_rem),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_rem(out_rem), .out_err(out_err),
    .busy(busy)
  );

  typedef struct packed {
    logic [5:0] q;
    logic [6:0] r;
    logic [1:0] e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter: incremented on every rising edge, read only at falling edges.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Divider model. done_delay=0 means the divider never answers.
  int done_delay = 7;
  int dcnt = 0;
  int start_cnt = 0;
  logic [11:0] start_dividend = 12'd0;
  logic [5:0]  start_divisor = 6'd0;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (div_start) begin
      start_cnt++;
      start_dividend = div_dividend;
      start_divisor  = div_divisor;
      dcnt = done_delay;
    end else if (dcnt != 0) begin
      dcnt--;
      if (dcnt == 0) begin
        div_done = 1'b1;
        if (div_divisor != 6'd0) begin
          div_quotient = 6'(div_dividend / 12'(div_divisor));
          div_rem      = 7'(div_dividend % 12'(div_divisor));
        end else begin
          div_quotient = 6'd0;
          div_rem      = 7'd0;
        end
      end
    end
  end

  // Result monitor: samples after the main process has driven its inputs, so
  // out_valid && out_ready here means the result is consumed at the next edge.
  int   rise_cyc = 0;
  int   outs = 0;
  logic ov_prev = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid) outs++;
    if (out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_quotient", 32'(out_quotient), 32'(e.q));
        check("out_rem", 32'(out_rem), 32'(e.r));
        check("out_err", 32'(out_err), 32'(e.e));
      end
    end
  end

  int acc_cyc = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for acceptance, push its expected result.
  task automatic send(input logic [11:0] d, input logic [5:0] v, input exp_t e);
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      tick();
    end
    check("send_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_dividend = d;
    in_divisor  = v;
    @(posedge clk);
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("drain_budget", 32'(sb.size()), 32'd0);
  endtask

  int s0;
  int o0;

  initial begin
    rst = 1'b1;
    tick();
    tick();
    // Reset values while rst is held.
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_out_bus", 32'({out_err, out_quotient, out_rem}), 32'd0);
    check("rst_div_bus", 32'({div_dividend, div_divisor}), 32'd0);
    rst = 1'b0;
    tick();

    // Normal: 100/7 = 14 r 2; ISSUE + 7 WAIT cycles before HOLD.
    s0 = start_cnt;
    send(12'd100, 6'd7, exp_t'{6'd14, 7'd2, 2'b00});
    wait_drain();
    check("norm_starts", 32'(start_cnt - s0), 32'd1);
    check("norm_div_operands", 32'({start_dividend, start_divisor}), 32'({12'd100, 6'd7}));
    check("norm_edges_to_valid", 32'(rise_cyc - acc_cyc), 32'd8);

    // Divide by zero: result valid in the cycle right after acceptance.
    s0 = start_cnt;
    send(12'd500, 6'd0, exp_t'{6'h3F, 7'd0, 2'b01});
    check("dbz_valid_next", 32'(out_valid), 32'd1);
    wait_drain();
    check("dbz_starts", 32'(start_cnt - s0), 32'd0);

    // Overflow: 4095[11:6]=63 >= 7.
    s0 = start_cnt;
    send(12'd4095, 6'd7, exp_t'{6'h3F, 7'd0, 2'b10});
    check("ovf_valid_next", 32'(out_valid), 32'd1);
    wait_drain();
    check("ovf_starts", 32'(start_cnt - s0), 32'd0);

    // Boundary just below overflow: 447[11:6]=6 < 7, 447/7 = 63 r 6.
    s0 = start_cnt;
    send(12'd447, 6'd7, exp_t'{6'd63, 7'd6, 2'b00});
    wait_drain();
    check("edge_starts", 32'(start_cnt - s0), 32'd1);

    // Timeout: divider silent; out_valid rises 33 edges after the acceptance edge.
    done_delay = 0;
    send(12'd100, 6'd7, exp_t'{6'h3F, 7'd0, 2'b11});
    wait_drain();
    check("tmo_edges_to_valid", 32'(rise_cyc - acc_cyc), 32'd33);
    done_delay = 7;

    // Backpressure: hold out_ready low for 10 cycles in HOLD.
    out_ready = 1'b0;
    send(12'd100, 6'd7, exp_t'{6'd14, 7'd2, 2'b00});
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      tick();
    end
    check("bp_reached_hold", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_stable", 32'({out_valid, in_ready, busy, out_err, out_quotient, out_rem}),
            32'({1'b1, 1'b0, 1'b1, 2'b00, 6'd14, 7'd2}));
    end
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_released", 32'({out_valid, in_ready, busy}), 32'(3'b010));
    send(12'd447, 6'd7, exp_t'{6'd63, 7'd6, 2'b00});
    wait_drain();

    // Reset three cycles after div_start; the in-flight result is dropped and
    // the divider's late done must be ignored.
    send(12'd200, 6'd7, exp_t'{6'd28, 7'd4, 2'b00});
    for (int i = 0; i < 20; i++) begin
      if (div_start) break;
      tick();
    end
    check("rw_start_seen", 32'(div_start), 32'd1);
    tick();
    tick();
    tick();
    check("rw_in_wait", 32'({busy, div_start, out_valid}), 32'(3'b100));
    rst = 1'b1;
    #1;
    check("rw_reset_ctrl", 32'({in_ready, busy, out_valid, div_start}), 32'(4'b1000));
    check("rw_reset_out", 32'({out_err, out_quotient, out_rem}), 32'd0);
    check("rw_reset_div", 32'({div_dividend, div_divisor}), 32'd0);
    sb.delete();
    o0 = outs;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("rw_no_valid", 32'(outs - o0), 32'd0);
    check("rw_idle", 32'({busy, in_ready}), 32'(2'b01));

    // First request after reset is accepted normally.
    send(12'd100, 6'd7, exp_t'{6'd14, 7'd2, 2'b00});
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
